neuron_activate: RTL and testbench

- Downstream stage of the neuron accumulator. Takes each finished signed 8-bit accumulator result on a valid strobe and applies a selectable activation function.
- Buffers results in a small FIFO and presents them to the next layer over a valid/ready handshake.
- Decouples the accumulator's fixed cadence from a possibly stalling consumer.

---
 rtl/neuron_activate_if.sv | 30 +++
 rtl/neuron_activate.sv | 91 +++++++++
 tb/tb_neuron_activate.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/neuron_activate_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | neuron_activate_if : activation-stage handshake bundle (in + out streams)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface neuron_activate_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                             in_valid;
  logic                             in_ready;
  logic signed [DATA_W-1:0]         accu;
  logic [1:0]                       act_sel;
  logic                             out_valid;
  logic                             out_ready;
  logic signed [DATA_W-1:0]         y;
  logic [$clog2(FIFO_DEPTH):0]      fifo_count;
  logic                             overflow;

  modport master (
    output in_valid, accu, act_sel, out_ready,
    input  in_ready, out_valid, y, fifo_count, overflow
  );

  modport slave (
    input  in_valid, accu, act_sel, out_ready,
    output in_ready, out_valid, y, fifo_count, overflow
  );
endinterface
`default_nettype wire

// File: rtl/neuron_activate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | neuron_activate : activation stage (identity/ReLU/step/leaky) + out FIFO   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module neuron_activate #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int THRESH     = 0
) (
  input  logic              clk,
  input  logic              rst,
  neuron_activate_if.slave  bus
);
  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic signed [DATA_W-1:0] c_thresh = DATA_W'(THRESH);
  localparam logic [c_cw:0]            c_depth  = (c_cw+1)'(FIFO_DEPTH);
  localparam logic signed [DATA_W-1:0] c_one    = {{(DATA_W-1){1'b0}}, 1'b1};

  logic signed [DATA_W-1:0] s1_accu_q, s1_accu_d;
  logic [1:0]               s1_sel_q, s1_sel_d;
  logic                     s1_valid_q, s1_valid_d;
  logic signed [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [c_aw-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0]          count_q, count_d;
  logic                     overflow_q, overflow_d;

  logic signed [DATA_W-1:0] act;
  logic                     accept, push, pop;

  // Any item sitting in s1 is reserved a FIFO slot here, so a push never finds the FIFO full.
  assign bus.in_ready = rst && (({1'b0, count_q} + {{c_cw{1'b0}}, s1_valid_q}) < c_depth);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = s1_valid_q;
  assign pop          = (count_q != '0) && bus.out_ready;

  always_comb begin
    act = s1_accu_q;
    case (s1_sel_q)
      2'b01:   act = s1_accu_q[DATA_W-1] ? '0 : s1_accu_q;
      2'b10:   act = (s1_accu_q > c_thresh) ? c_one : '0;
      2'b11:   act = s1_accu_q[DATA_W-1] ? (s1_accu_q >>> 2) : s1_accu_q;
      default: act = s1_accu_q;
    endcase
  end

  always_comb begin
    s1_valid_d = accept;
    s1_accu_d  = accept ? bus.accu    : s1_accu_q;
    s1_sel_d   = accept ? bus.act_sel : s1_sel_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + {{(c_cw-1){1'b0}}, push} - {{(c_cw-1){1'b0}}, pop};
    overflow_d = overflow_q | (bus.in_valid & ~bus.in_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_accu_q  <= '0;
      s1_sel_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_accu_q  <= s1_accu_d;
      s1_sel_q   <= s1_sel_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[wr_ptr_q] <= act;
    end
  end

  assign bus.out_valid  = (count_q != '0);
  assign bus.y          = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_activate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_neuron_activate : directed + random bench against a queue-based model   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_neuron_activate;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int THRESH     = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  neuron_activate_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  neuron_activate #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .THRESH(THRESH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int maxcnt = 0;

  // Reference model: queue of activated results, optional stage item, sticky flag.
  int q[$];
  bit m_s1v = 1'b0;
  int m_s1a = 0;
  int m_s1s = 0;
  bit m_ovf = 1'b0;
  int got[$];

  function automatic int act_ref(input int a, input int sel);
    case (sel)
      0: return a;
      1: return (a < 0) ? 0 : a;
      2: return (a > THRESH) ? 1 : 0;
      default: return (a < 0) ? -((-a + 3) / 4) : a;
    endcase
  endfunction

  function automatic bit m_rdy();
    return (q.size() + int'(m_s1v)) < FIFO_DEPTH;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input int a, input int s, input bit ordy, input bit rdy);
    if (!r) begin
      q.delete();
      m_s1v = 1'b0;
      m_ovf = 1'b0;
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (m_s1v) q.push_back(act_ref(m_s1a, m_s1s));
      if (v && !rdy) m_ovf = 1'b1;
      if (v && rdy) begin
        m_s1v = 1'b1; m_s1a = a; m_s1s = s;
      end else begin
        m_s1v = 1'b0;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input int a, input int s, input bit ordy);
    bit exp_rdy;
    rst           = r;
    bus.in_valid  = v;
    bus.accu      = DATA_W'(a);
    bus.act_sel   = 2'(s);
    bus.out_ready = ordy;
    #1;
    exp_rdy = r && m_rdy();
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    if (r && bus.out_valid && ordy) got.push_back(int'(bus.y));
    @(posedge clk);
    model_edge(r, v, a, s, ordy, exp_rdy);
    #1;
    chk("out_valid",  {31'd0, bus.out_valid}, (q.size() != 0) ? 1 : 0);
    chk("y",          bus.y, (q.size() != 0) ? q[0] : 0);
    chk("fifo_count", {28'd0, bus.fifo_count}, q.size());
    chk("overflow",   {31'd0, bus.overflow}, {31'd0, m_ovf});
    if (int'(bus.fifo_count) > maxcnt) maxcnt = int'(bus.fifo_count);
  endtask

  task automatic check_got(input string tag, input int exp[$]);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(tag, got[i], exp[i]);
    got.delete();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (q.size() != 0 || m_s1v); i++) step(1, 0, 0, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int guard;
    bit tog;
    bus.in_valid = 1'b0; bus.accu = '0; bus.act_sel = '0; bus.out_ready = 1'b0;

    // Reset, then a single ReLU input
    step(0, 0, 0, 0, 0);
    step(0, 1, 5, 0, 1);
    chk("rst_count", {28'd0, bus.fifo_count}, 0);
    step(1, 1, 13, 1, 0);
    step(1, 0, 0, 0, 0);
    chk("single_y", bus.y, 13);
    chk("single_valid", {31'd0, bus.out_valid}, 1);
    step(1, 0, 0, 0, 1);
    chk("single_pop_valid", {31'd0, bus.out_valid}, 0);
    chk("single_pop_y", bus.y, 0);
    got.delete();

    // Activation sweep, out_ready held high
    for (int s = 0; s < 4; s++) step(1, 1, -5, s, 1);
    step(1, 1, -128, 3, 1);
    step(1, 1, 0, 2, 1);
    step(1, 1, 1, 2, 1);
    step(1, 1, 127, 1, 1);
    drain(10);
    check_got("sweep", '{-5, 0, 0, -2, -32, 0, 1, 127});

    // Backpressure to full, then overflow on a held 5th input
    step(0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) step(1, 1, 10 * k, 0, 0);
    chk("full_rdy", {31'd0, bus.in_ready}, 0);
    step(1, 1, 50, 0, 0);
    step(1, 1, 50, 0, 0);
    chk("ovf_set", {31'd0, bus.overflow}, 1);
    chk("full_count", {28'd0, bus.fifo_count}, 4);
    got.delete();
    drain(10);
    check_got("order", '{10, 20, 30, 40});

    // Full, pop one, refill with 7
    step(0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) step(1, 1, k, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("refill_full", {28'd0, bus.fifo_count}, 4);
    got.delete();
    step(1, 0, 0, 0, 1);
    step(1, 1, 7, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("refill_ovf", {31'd0, bus.overflow}, 0);
    drain(10);
    check_got("refill", '{1, 2, 3, 4, 7});

    // Wrap-around with toggling consumer
    step(0, 0, 0, 0, 0);
    maxcnt = 0; sent = 0; guard = 0; tog = 1'b1;
    while ((sent < 12 || q.size() != 0 || m_s1v) && guard < 200) begin
      if (sent < 12 && m_rdy()) begin
        step(1, 1, sent + 1, 0, tog);
        sent++;
      end else begin
        step(1, 0, 0, 0, tog);
      end
      tog = ~tog;
      guard++;
    end
    check_got("wrap", '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12});
    chk("wrap_max", {31'd0, maxcnt <= FIFO_DEPTH}, 1);

    // Reset mid-stream with s1 occupied
    for (int k = 1; k <= 4; k++) step(1, 1, k, 0, 0);
    chk("mid_count", {28'd0, bus.fifo_count}, 3);
    step(0, 0, 0, 0, 0);
    chk("mid_rst_count", {28'd0, bus.fifo_count}, 0);
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 0);
    chk("mid_rst_y", bus.y, 0);
    step(1, 1, 9, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("post_rst_y", bus.y, 9);
    drain(10);
    got.delete();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit r;
      bit v;
      r = ($urandom_range(0, 63) != 0);
      v = m_rdy() ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      step(r, v, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
